// File: rtl/reaction_pkg.sv
// Shared constants for the reaction-time game controller: state codes,
// display mux select codes and fixed output patterns.
package reaction_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ARM    = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] GO     = 3'd3;
  localparam logic [2:0] RESULT = 3'd4;
  localparam logic [2:0] FAULT  = 3'd5;

  localparam logic [1:0] SEL_TIME  = 2'b00;
  localparam logic [1:0] SEL_BEST  = 2'b01;
  localparam logic [1:0] SEL_FAULT = 2'b10;
  localparam logic [1:0] SEL_BLANK = 2'b11;

  // Alternating LED pattern, MSB lit; truncated to the LED bank width
  localparam logic [31:0] FAULT_LED_PATTERN = 32'hAAAA_AAAA;

  // Truncated to the winner width, still all-ones
  localparam logic [31:0] NO_WINNER = 32'hFFFF_FFFF;

endpackage

// File: rtl/press_arbiter.sv
// Per-player rising-edge detection, false-start mask and lowest-index
// priority selection among unmasked edges.
module press_arbiter #(
  parameter int unsigned N_PLAYERS = 2,
  parameter int unsigned IDX_W     = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_PLAYERS-1:0] p,
  input  logic                 clear_mask,
  input  logic                 mask_en,
  output logic                 any_edge,
  output logic                 any_unmasked_edge,
  output logic [IDX_W-1:0]     first_idx,
  output logic                 mask_full_c
);

  logic [N_PLAYERS-1:0] p_q;
  logic [N_PLAYERS-1:0] rise_q;
  logic [N_PLAYERS-1:0] mask_q;
  logic [N_PLAYERS-1:0] unmasked;

  // p_q resets high so a button held through reset is never seen as an edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p_q    <= '1;
      rise_q <= '0;
      mask_q <= '0;
    end else begin
      p_q    <= p;
      rise_q <= p & ~p_q;
      if (clear_mask) begin
        mask_q <= '0;
      end else if (mask_en) begin
        mask_q <= mask_q | rise_q;
      end
    end
  end

  assign unmasked          = rise_q & ~mask_q;
  assign any_edge          = |rise_q;
  assign any_unmasked_edge = |unmasked;
  assign mask_full_c       = &(mask_q | rise_q);

  // Lowest index wins on simultaneous edges
  always_comb begin
    first_idx = '0;
    for (int i = int'(N_PLAYERS) - 1; i >= 0; i--) begin
      if (unmasked[i]) first_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/reaction_game_ctrl.sv
// Reaction-time game controller: random delay, LED go signal, first valid
// press timing, false-start disqualification and best-time record.
module reaction_game_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned N_PLAYERS = 2,
  parameter int unsigned TIME_W    = 20,
  parameter int unsigned RND_W     = 12,
  parameter int unsigned MIN_DELAY = 1000,
  parameter int unsigned LED_W     = 10
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        tick,
  input  logic                        resume,
  input  logic [N_PLAYERS-1:0]        p,
  input  logic                        rnd_ready,
  input  logic [RND_W-1:0]            rnd_value,
  output logic                        rng_resume,
  output logic [LED_W-1:0]            LEDs,
  output logic [1:0]                  MUL_sel,
  output logic [TIME_W-1:0]           output_num,
  output logic [$clog2(N_PLAYERS):0]  winner
);

  localparam int unsigned WIN_W = $clog2(N_PLAYERS) + 1;
  localparam int unsigned DLY_W = RND_W + 1;
  localparam logic [TIME_W-1:0] TIME_MAX = '1;
  localparam logic [WIN_W-1:0]  WIN_NONE = WIN_W'(NO_WINNER);

  logic [2:0]        state, state_n;
  logic [DLY_W-1:0]  delay_q, delay_n;
  logic [TIME_W-1:0] time_q, time_n;
  logic [TIME_W-1:0] cap_q, cap_n;
  logic [TIME_W-1:0] best_q, best_n;
  logic [WIN_W-1:0]  winner_n;
  logic              resume_q, resume_rise;

  logic              rng_n;
  logic [LED_W-1:0]  led_n;
  logic [1:0]        sel_n;
  logic [TIME_W-1:0] num_n;

  logic              any_edge, any_unmasked_edge, mask_full_c;
  logic [WIN_W-1:0]  first_idx;

  press_arbiter #(
    .N_PLAYERS (N_PLAYERS),
    .IDX_W     (WIN_W)
  ) u_press_arbiter (
    .clock             (clock),
    .reset             (reset),
    .p                 (p),
    .clear_mask        ((state == ARM) && rnd_ready),
    .mask_en           (state == WAIT),
    .any_edge          (any_edge),
    .any_unmasked_edge (any_unmasked_edge),
    .first_idx         (first_idx),
    .mask_full_c       (mask_full_c)
  );

  assign resume_rise = resume & ~resume_q;

  // Next state and datapath
  always_comb begin
    state_n  = state;
    delay_n  = delay_q;
    time_n   = time_q;
    cap_n    = cap_q;
    best_n   = best_q;
    winner_n = winner;
    case (state)
      IDLE: begin
        if (resume_rise) begin
          state_n  = ARM;
          winner_n = WIN_NONE;
        end
      end
      ARM: begin
        if (rnd_ready) begin
          delay_n = DLY_W'(MIN_DELAY) + DLY_W'(rnd_value);
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (any_edge && mask_full_c) begin
          state_n = FAULT;
        end else if (tick) begin
          // The tick that takes the delay to zero is the one that lights the LEDs
          if (delay_q <= DLY_W'(1)) begin
            state_n = GO;
            time_n  = '0;
          end else begin
            delay_n = delay_q - DLY_W'(1);
          end
        end
      end
      GO: begin
        if (any_unmasked_edge) begin
          cap_n    = time_q;
          winner_n = first_idx;
          state_n  = RESULT;
          if (time_q < best_q) best_n = time_q;
        end else if (time_q == TIME_MAX) begin
          cap_n    = TIME_MAX;
          winner_n = WIN_NONE;
          state_n  = RESULT;
        end else if (tick) begin
          time_n = time_q + TIME_W'(1);
        end
      end
      RESULT, FAULT: begin
        if (resume_rise) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Output values for the state being entered
  always_comb begin
    rng_n = 1'b0;
    led_n = '0;
    sel_n = SEL_BLANK;
    num_n = '0;
    case (state_n)
      IDLE: begin
        sel_n = SEL_BEST;
        num_n = best_n;
      end
      ARM: rng_n = 1'b1;
      GO: begin
        led_n = '1;
        sel_n = SEL_TIME;
        num_n = time_n;
      end
      RESULT: begin
        sel_n = SEL_TIME;
        num_n = cap_n;
        if (winner_n != WIN_NONE) led_n = LED_W'(1) << winner_n;
      end
      FAULT: begin
        led_n = LED_W'(FAULT_LED_PATTERN);
        sel_n = SEL_FAULT;
      end
      default: ;
    endcase
  end

  // resume_q resets high so a resume held across reset cannot start a game
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      delay_q    <= '0;
      time_q     <= '0;
      cap_q      <= '0;
      best_q     <= TIME_MAX;
      winner     <= WIN_NONE;
      resume_q   <= 1'b1;
      rng_resume <= 1'b0;
      LEDs       <= '0;
      MUL_sel    <= SEL_BEST;
      output_num <= TIME_MAX;
    end else begin
      state      <= state_n;
      delay_q    <= delay_n;
      time_q     <= time_n;
      cap_q      <= cap_n;
      best_q     <= best_n;
      winner     <= winner_n;
      resume_q   <= resume;
      rng_resume <= rng_n;
      LEDs       <= led_n;
      MUL_sel    <= sel_n;
      output_num <= num_n;
    end
  end

endmodule
